// File: rtl/vga_timing_gen_if.sv
// Signal bundle between vga_timing_gen (master), its paint block and the DAC.
// test_mode exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_gen_if #(
  parameter int CW    = 8,
  parameter int CNT_W = 10
);
  logic             pix_en;
  logic             clk_vga;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             req_valid;
  logic [3*CW-1:0]  rgb_in;
  logic             hsync;
  logic             vsync;
  logic             blank_n;
  logic             sync_n;
  logic [CW-1:0]    red;
  logic [CW-1:0]    green;
  logic [CW-1:0]    blue;
  logic             sof;
  logic [7:0]       frame_cnt;
`ifdef VGA_TEST_PATTERN_EN
  logic             test_mode;
`endif

  modport master (
    output pix_en, clk_vga, x, y, req_valid,
    output hsync, vsync, blank_n, sync_n, red, green, blue, sof, frame_cnt,
`ifdef VGA_TEST_PATTERN_EN
    input  test_mode,
`endif
    input  rgb_in
  );

  modport slave (
    input  pix_en, clk_vga, x, y, req_valid,
    input  hsync, vsync, blank_n, sync_n, red, green, blue, sof, frame_cnt,
`ifdef VGA_TEST_PATTERN_EN
    output test_mode,
`endif
    output rgb_in
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Generic raster timing generator with pixel-enable divider and paint-latency alignment.
// Optional VGA_TEST_PATTERN_EN adds test_mode, replacing rgb_in with 8 vertical colour bars.
module vga_timing_gen #(
  parameter int HACTIVE   = 640,
  parameter int HFP       = 16,
  parameter int HSYN      = 96,
  parameter int HBP       = 48,
  parameter int VACTIVE   = 480,
  parameter int VFP       = 10,
  parameter int VSYN      = 2,
  parameter int VBP       = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CLK_DIV   = 2,
  parameter int PIPE      = 1,
  parameter int CW        = 8,
  parameter int CNT_W     = 10
) (
  input  logic               clk,
  input  logic               rst,
  vga_timing_gen_if.master   io_vga
);

  localparam int HTOTAL = HACTIVE + HFP + HSYN + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSYN + VBP;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HTOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VTOTAL - 1);

  typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYN, PH_BP} phase_t;

  function automatic phase_t decode_phase(input logic [CNT_W-1:0] cnt,
                                          input int act, input int fp, input int syn);
    int c;
    c = int'(cnt);
    if (c < act)                  return PH_ACT;
    else if (c < act + fp)        return PH_FP;
    else if (c < act + fp + syn)  return PH_SYN;
    else                          return PH_BP;
  endfunction

  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_nxt;
  logic             w_pix_en;
  logic             r_clk_vga;

  assign w_div_nxt = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
  assign w_pix_en  = !rst && (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_clk_vga <= 1'b0;
    end else begin
      r_div_cnt <= w_div_nxt;
      // Registered from the next divider value so clk_vga tracks div_cnt >= CLK_DIV/2.
      r_clk_vga <= (CLK_DIV >= 2) && (int'(w_div_nxt) >= CLK_DIV / 2);
    end
  end

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic [CNT_W-1:0] w_h_nxt;
  logic [CNT_W-1:0] w_v_nxt;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_sof;
  logic [7:0]       r_frame_cnt;

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);
  assign w_sof    = w_pix_en && w_h_wrap && w_v_wrap;

  always_comb begin
    w_h_nxt = r_h_cnt;
    w_v_nxt = r_v_cnt;
    if (w_pix_en) begin
      w_h_nxt = w_h_wrap ? '0 : r_h_cnt + 1'b1;
      if (w_h_wrap) w_v_nxt = w_v_wrap ? '0 : r_v_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
      if (w_sof) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  phase_t r_hph, w_hph_nxt;
  phase_t r_vph, w_vph_nxt;
  logic   w_raw_act;
  logic   w_raw_hs;
  logic   w_raw_vs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hph <= PH_ACT;
      r_vph <= PH_ACT;
    end else begin
      r_hph <= w_hph_nxt;
      r_vph <= w_vph_nxt;
    end
  end

  // Phase follows the counter value being loaded, so it never lags h_cnt/v_cnt.
  always_comb begin
    w_hph_nxt = decode_phase(w_h_nxt, HACTIVE, HFP, HSYN);
    w_vph_nxt = decode_phase(w_v_nxt, VACTIVE, VFP, VSYN);
  end

  always_comb begin
    w_raw_act = (r_hph == PH_ACT) && (r_vph == PH_ACT);
    w_raw_hs  = (r_hph == PH_SYN);
    w_raw_vs  = (r_vph == PH_SYN);
  end

  // p0 -> pPIPE+1: raw region flags delayed on pix_en; chain[PIPE] gates rgb, chain[PIPE+1] drives out.
  logic [PIPE:0]   r_act_sr;
  logic [PIPE:0]   r_hs_sr;
  logic [PIPE:0]   r_vs_sr;
  logic [PIPE+1:0] w_act_chain;
  logic [PIPE+1:0] w_hs_chain;
  logic [PIPE+1:0] w_vs_chain;

  assign w_act_chain = {r_act_sr, w_raw_act};
  assign w_hs_chain  = {r_hs_sr,  w_raw_hs};
  assign w_vs_chain  = {r_vs_sr,  w_raw_vs};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_sr <= '0;
      r_hs_sr  <= '0;
      r_vs_sr  <= '0;
    end else if (w_pix_en) begin
      r_act_sr <= w_act_chain[PIPE:0];
      r_hs_sr  <= w_hs_chain[PIPE:0];
      r_vs_sr  <= w_vs_chain[PIPE:0];
    end
  end

  logic [3*CW-1:0] w_rgb_src;

`ifdef VGA_TEST_PATTERN_EN
  function automatic logic [3*CW-1:0] bar_rgb(input logic [2:0] bar);
    return {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
  endfunction

  logic [2:0] w_bar_p0;
  logic [2:0] w_bar_tap;

  always_comb begin
    w_bar_p0 = 3'd0;
    for (int i = 1; i < 8; i++)
      if (int'(r_h_cnt) >= (i * HACTIVE) / 8) w_bar_p0 = 3'(i);
  end

  generate
    if (PIPE == 0) begin : g_bar_nodly
      assign w_bar_tap = w_bar_p0;
    end else begin : g_bar_dly
      logic [3*PIPE-1:0] r_bar_sr;
      logic [3*PIPE+2:0] w_bar_chain;
      assign w_bar_chain = {r_bar_sr, w_bar_p0};
      always_ff @(posedge clk)
        if (w_pix_en) r_bar_sr <= w_bar_chain[3*PIPE-1:0];
      assign w_bar_tap = w_bar_chain[3*PIPE+2 -: 3];
    end
  endgenerate

  assign w_rgb_src = io_vga.test_mode ? bar_rgb(w_bar_tap) : io_vga.rgb_in;
`else
  assign w_rgb_src = io_vga.rgb_in;
`endif

  // pPIPE -> pPIPE+1: colour capture, blanked outside the active region
  logic [3*CW-1:0] r_rgb_p1;

  always_ff @(posedge clk) begin
    if (rst)           r_rgb_p1 <= '0;
    else if (w_pix_en) r_rgb_p1 <= w_act_chain[PIPE] ? w_rgb_src : '0;
  end

  assign io_vga.pix_en    = w_pix_en;
  assign io_vga.clk_vga   = r_clk_vga;
  assign io_vga.x         = r_h_cnt;
  assign io_vga.y         = r_v_cnt;
  assign io_vga.req_valid = w_raw_act;
  assign io_vga.hsync     = w_hs_chain[PIPE+1] ? HSYNC_POL : ~HSYNC_POL;
  assign io_vga.vsync     = w_vs_chain[PIPE+1] ? VSYNC_POL : ~VSYNC_POL;
  assign io_vga.blank_n   = w_act_chain[PIPE+1];
  assign io_vga.sync_n    = 1'b0;
  assign io_vga.red       = r_rgb_p1[3*CW-1 -: CW];
  assign io_vga.green     = r_rgb_p1[2*CW-1 -: CW];
  assign io_vga.blue      = r_rgb_p1[CW-1:0];
  assign io_vga.sof       = w_sof;
  assign io_vga.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small 15x8 raster plus a default-mode instance.
module tb_vga_timing_gen;
  localparam int CW    = 8;
  localparam int CNT_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(CW), .CNT_W(CNT_W)) vif   ();
  vga_timing_gen_if #(.CW(CW), .CNT_W(CNT_W)) vif_d ();

  vga_timing_gen #(
    .HACTIVE(8), .HFP(2), .HSYN(3), .HBP(2),
    .VACTIVE(4), .VFP(1), .VSYN(2), .VBP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .CLK_DIV(2), .PIPE(1), .CW(CW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .io_vga(vif)
  );

  vga_timing_gen dut_d (
    .clk(clk), .rst(rst), .io_vga(vif_d)
  );

  typedef struct {
    logic        rst;
    logic [23:0] rgb;
    logic        e_pix;
    logic        e_cv;
    int          e_x;
    int          e_y;
    logic        e_req;
    logic        e_bl;
    logic [23:0] e_rgb;
    logic        e_hs;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_xy(input int wx, input int wy);
    int n;
    n = 0;
    while (!(vif.pix_en && vif.x == wx && vif.y == wy) && n < 600) begin
      tick();
      n++;
    end
    if (n >= 600) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_xy(%0d,%0d): not reached within %0d clk", wx, wy, n);
    end
  endtask

  task automatic wait_sof();
    int n;
    n = 0;
    while (!vif.sof && n < 600) begin
      tick();
      n++;
    end
    if (!vif.sof) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_sof: no sof within %0d clk", n);
    end
  endtask

  function automatic logic [23:0] rgb_out();
    return {vif.red, vif.green, vif.blue};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   exp_hs[15];
    int   exp_bl[15];
    int   ex, ey, xy_err, n_pix, n_req, n_bl, n_white, n_leak, n_hs, n_vs, n_vs_tick, n_sof;
    int   per, lo;
    logic prev, found, rise;

    vecs[0] = '{1'b1, 24'h000000, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 24'h000000, 1'b1};
    vecs[1] = '{1'b0, 24'h000000, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 24'h000000, 1'b1};
    vecs[2] = '{1'b0, 24'h000000, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0, 24'h000000, 1'b1};
    vecs[3] = '{1'b0, 24'h000000, 1'b1, 1'b1, 1, 0, 1'b1, 1'b0, 24'h000000, 1'b1};
    vecs[4] = '{1'b0, 24'h123456, 1'b0, 1'b0, 2, 0, 1'b1, 1'b1, 24'h123456, 1'b1};
    vecs[5] = '{1'b0, 24'hFFFFFF, 1'b1, 1'b1, 2, 0, 1'b1, 1'b1, 24'h123456, 1'b1};
    vecs[6] = '{1'b0, 24'hA5C3E1, 1'b0, 1'b0, 3, 0, 1'b1, 1'b1, 24'hA5C3E1, 1'b1};
    vecs[7] = '{1'b0, 24'h000000, 1'b1, 1'b1, 3, 0, 1'b1, 1'b1, 24'hA5C3E1, 1'b1};
    vecs[8] = '{1'b0, 24'h000000, 1'b0, 1'b0, 4, 0, 1'b1, 1'b1, 24'h000000, 1'b1};
    exp_hs  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    exp_bl  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};

    vif.rgb_in   = '0;
    vif_d.rgb_in = '0;
`ifdef VGA_TEST_PATTERN_EN
    vif.test_mode   = 1'b0;
    vif_d.test_mode = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) tick();
    check("rst_sync_n",    vif.sync_n,    0);
    check("rst_sof",       vif.sof,       0);
    check("rst_frame_cnt", vif.frame_cnt, 0);
    check("rst_vsync",     vif.vsync,     1);

    // Release from reset and first pixels
    for (int i = 0; i < 9; i++) begin
      rst        = vecs[i].rst;
      vif.rgb_in = vecs[i].rgb;
      tick();
      check($sformatf("v%0d_pix_en", i),    vif.pix_en,    vecs[i].e_pix);
      check($sformatf("v%0d_clk_vga", i),   vif.clk_vga,   vecs[i].e_cv);
      check($sformatf("v%0d_x", i),         vif.x,         vecs[i].e_x);
      check($sformatf("v%0d_y", i),         vif.y,         vecs[i].e_y);
      check($sformatf("v%0d_req_valid", i), vif.req_valid, vecs[i].e_req);
      check($sformatf("v%0d_blank_n", i),   vif.blank_n,   vecs[i].e_bl);
      check($sformatf("v%0d_rgb", i),       rgb_out(),     vecs[i].e_rgb);
      check($sformatf("v%0d_hsync", i),     vif.hsync,     vecs[i].e_hs);
    end

    // One full line (y=1): hsync and blank_n lag the counter by two pixel ticks
    wait_xy(0, 1);
    for (int xi = 0; xi < 15; xi++) begin
      check($sformatf("line_x%0d", xi),       vif.x,       xi);
      check($sformatf("line_hsync_x%0d", xi), vif.hsync,   exp_hs[xi]);
      check($sformatf("line_blank_x%0d", xi), vif.blank_n, exp_bl[xi]);
      tick();
      tick();
    end

    // Whole-frame statistics with white paint input
    vif.rgb_in = 24'hFFFFFF;
    wait_sof();
    check("sof_at_x", vif.x, 14);
    check("sof_at_y", vif.y, 7);
    tick();
    ex = 0; ey = 0; xy_err = 0; n_pix = 0; n_req = 0; n_bl = 0; n_white = 0;
    n_leak = 0; n_hs = 0; n_vs = 0; n_vs_tick = 0; n_sof = 0;
    for (int i = 0; i < 240; i++) begin
      if (vif.pix_en) begin
        n_pix++;
        if (vif.x != ex || vif.y != ey) xy_err++;
        if (vif.req_valid) n_req++;
        if (!vif.vsync) n_vs_tick++;
        ex++;
        if (ex == 15) begin
          ex = 0;
          ey = (ey + 1) % 8;
        end
      end
      if (vif.blank_n) n_bl++;
      if (vif.blank_n && rgb_out() == 24'hFFFFFF) n_white++;
      if (!vif.blank_n && rgb_out() != 24'h0) n_leak++;
      if (!vif.hsync) n_hs++;
      if (!vif.vsync) n_vs++;
      if (vif.sof) n_sof++;
      tick();
    end
    check("frame_xy_sequence_errors", xy_err,    0);
    check("frame_pix_ticks",          n_pix,     120);
    check("frame_req_valid_ticks",    n_req,     32);
    check("frame_blank_n_clk",        n_bl,      64);
    check("frame_white_clk",          n_white,   64);
    check("frame_rgb_leak_clk",       n_leak,    0);
    check("frame_hsync_low_clk",      n_hs,      48);
    check("frame_vsync_low_clk",      n_vs,      60);
    check("frame_vsync_low_ticks",    n_vs_tick, 30);
    check("frame_sof_count",          n_sof,     1);

    // Reset pulse mid-frame at (5,2)
    wait_xy(5, 2);
    check("pre_rst_blank_n", vif.blank_n, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_pix_en",    vif.pix_en,    0);
    check("mid_rst_clk_vga",   vif.clk_vga,   0);
    check("mid_rst_x",         vif.x,         0);
    check("mid_rst_y",         vif.y,         0);
    check("mid_rst_blank_n",   vif.blank_n,   0);
    check("mid_rst_rgb",       rgb_out(),     0);
    check("mid_rst_hsync",     vif.hsync,     1);
    check("mid_rst_vsync",     vif.vsync,     1);
    check("mid_rst_sof",       vif.sof,       0);
    check("mid_rst_frame_cnt", vif.frame_cnt, 0);
    rst = 1'b0;
    tick();
    check("post_rst_pix_en", vif.pix_en, 1);
    check("post_rst_x",      vif.x,      0);
    check("post_rst_y",      vif.y,      0);
    tick();
    tick();
    check("post_rst_pix_en2", vif.pix_en, 1);
    check("post_rst_x2",      vif.x,      1);

`ifdef VGA_TEST_PATTERN_EN
    vif.test_mode = 1'b1;
    vif.rgb_in    = 24'h5A5A5A;
    wait_xy(2, 0);
    check("bar0_blank_n", vif.blank_n, 1);
    check("bar0_black",   rgb_out(),   24'h000000);
    wait_xy(3, 0);
    check("bar1_blue",    rgb_out(),   24'h0000FF);
    wait_xy(6, 0);
    check("bar4_red",     rgb_out(),   24'hFF0000);
    wait_xy(9, 0);
    check("bar7_white",   rgb_out(),   24'hFFFFFF);
    vif.test_mode = 1'b0;
`endif

    // Default 640x480 instance: hsync period and width in clk cycles
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      prev = vif_d.hsync;
      tick();
      if (prev && !vif_d.hsync) found = 1'b1;
    end
    check("dflt_hsync_fall_seen", found, 1);
    per = 0; lo = 1; rise = 1'b0; found = 1'b0;
    while (!found && per < 4000) begin
      prev = vif_d.hsync;
      tick();
      per++;
      if (vif_d.hsync) rise = 1'b1;
      else if (!rise) lo++;
      if (prev && !vif_d.hsync) found = 1'b1;
    end
    check("dflt_hsync_period_clk", per, 1600);
    check("dflt_hsync_low_clk",    lo,  192);

    // 256 frames: frame_cnt wraps 255 -> 0
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int f = 1; f <= 256; f++) begin
      wait_sof();
      tick();
      if (f == 1 || f == 2 || f == 255 || f == 256)
        check($sformatf("frame_cnt_after_sof%0d", f), vif.frame_cnt, f % 256);
      if (f == 256) begin
        check("wrap_x", vif.x, 0);
        check("wrap_y", vif.y, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
